iex_result_reg: RTL
===================

Name: iex_result_reg

Overview:
- Execute-to-memory pipeline register that sits directly downstream of the ALU sub-units in iex: adder, shifter, logic unit and comparator.
- Each cycle it selects the active unit's result and screens the op for legality, using the shifter's valid flag.
- It then registers the result with the instruction's destination info under a valid/ready handshake, with kill and flush.
- It also drives the EX/MEM forwarding bus and a saturating illegal-op counter.

Parameters:
- DATA_WIDTH, 32, width of the operand/result datapath (matches `DATA_WIDTH).
- REG_ADDR_WIDTH, 5, register-file index width.
- PC_WIDTH, 32, program counter width.
- CNT_WIDTH, 8, width of the illegal-op counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_vld  in  1  valid instruction present in EX.
- ex_ready  out  1  register can accept this cycle.
- ex_kill  in  1  discard the EX instruction (wrong-path); no capture.
- pipe_flush  in  1  clear the held instruction and block capture.
- ex_pc  in  PC_WIDTH  PC of the EX instruction.
- ex_rd  in  REG_ADDR_WIDTH  destination register.
- ex_rd_wen  in  1  instruction writes rd.
- ex_alu_sel  in  2  result source: 0 adder, 1 shifter, 2 logic, 3 compare.
- adder_data_out  in  DATA_WIDTH  adder result.
- shifter_data_out  in  DATA_WIDTH  shifter result.
- shifter_output_vld  in  1  shifter control-combination legal flag.
- logic_data_out  in  DATA_WIDTH  logic-unit result.
- cmp_data_out  in  DATA_WIDTH  compare result (0/1, zero-extended).
- mem_vld  out  1  registered instruction valid toward MEM.
- mem_ready  in  1  MEM accepts this cycle.
- mem_pc  out  PC_WIDTH  registered PC.
- mem_rd  out  REG_ADDR_WIDTH  registered rd.
- mem_rd_wen  out  1  registered write enable (after qualification).
- mem_alu_result  out  DATA_WIDTH  registered selected result.
- mem_illegal_op  out  1  registered illegal-op flag.
- fwd_vld  out  1  forwarding entry valid.
- fwd_rd  out  REG_ADDR_WIDTH  forwarding destination.
- fwd_data  out  DATA_WIDTH  forwarding value.
- illegal_cnt  out  CNT_WIDTH  saturating count of captured illegal ops.

Behaviour:
- Reset (rst_n=0, asynchronous): every registered output and illegal_cnt go to 0 immediately and stay 0 while rst_n=0. Reset during a transfer drops the held instruction; there is no replay.
- ex_ready = !pipe_flush & (!mem_vld | mem_ready). This is combinational.
- Fire condition: fire = ex_vld & ex_ready & !ex_kill.
- On fire, in the next cycle:
  - mem_vld=1;
  - pc, rd and the selected result are captured;
  - illegal = (ex_alu_sel==1) & !shifter_output_vld;
  - mem_rd_wen = ex_rd_wen & !illegal & (ex_rd!=0);
  - mem_alu_result = 0 when illegal.
- Latency: 1 cycle from EX inputs to mem_* outputs.
- Drain without refill (mem_vld & mem_ready & !fire): mem_vld goes to 0. Data fields hold their values (don't-care).
- Stall (mem_vld & !mem_ready): all mem_* outputs hold. Upstream sees ex_ready=0.
- Simultaneous drain and fire: the new instruction replaces the old one back-to-back, giving full throughput.
- pipe_flush=1: mem_vld goes to 0 next cycle regardless of mem_ready. No capture occurs and the counter does not change. pipe_flush has priority over fire and ex_kill.
- ex_kill with ex_vld: the instruction is not captured. If the register was draining, mem_vld goes to 0.
- illegal_cnt increments by 1 on each fire with illegal=1. It saturates at 2^CNT_WIDTH-1 and clears only on reset.
- Forwarding outputs are combinational from the registers:
  - fwd_vld = mem_vld & mem_rd_wen;
  - fwd_rd = mem_rd;
  - fwd_data = mem_alu_result.
- ex_alu_sel values are all decoded, so no value of ex_alu_sel is undefined.

Test Plan:
- Reset mid-stream: assert rst_n=0 while mem_vld=1 -> all outputs 0 asynchronously, before the next clk edge; illegal_cnt=0.
- Shifter select: ex_vld=1, sel=1, shifter_out=0x0000_00F0, vld=1, rd=5, wen=1, mem_ready=1 -> next cycle mem_vld=1, mem_alu_result=0xF0, mem_rd=5, fwd_vld=1.
- Illegal shift: sel=1, shifter_output_vld=0, rd=7, wen=1 -> mem_illegal_op=1, mem_rd_wen=0, result=0, fwd_vld=0, illegal_cnt 0->1. After 300 such ops, illegal_cnt=255.
- Backpressure: mem_ready=0 for 3 cycles with a new ex_vld each cycle -> ex_ready=0, mem_* stable at the first instruction. Release -> the second instruction appears the next cycle, with no loss or duplication.
- Flush/kill: pipe_flush=1 with ex_vld=1 and mem_ready=0 -> next cycle mem_vld=0, counter unchanged. ex_kill=1, ex_vld=1, sel=1, shifter_output_vld=0 -> no capture, illegal_cnt unchanged.
- rd=x0: sel=0, adder_out=0x1234, rd=0, wen=1 -> mem_vld=1, mem_rd_wen=0, fwd_vld=0, mem_alu_result=0x1234.

Source files
------------

// File: rtl/iex_result_reg_if.sv
// EX/MEM result-register bundle: EX-side capture handshake, MEM-side output
// handshake, forwarding bus and the illegal-op counter.
//
// Handshake rules (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. A producer holding valid=1 keeps its payload
// stable until the transfer. Ready may depend combinationally on the
// consumer's state but never on the valid it is answering.
interface iex_result_reg_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PC_WIDTH       = 32,
  parameter int CNT_WIDTH      = 8
);
  // EX side
  logic                      ex_vld;
  logic                      ex_ready;
  logic                      ex_kill;
  logic                      pipe_flush;
  logic [PC_WIDTH-1:0]       ex_pc;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_rd_wen;
  logic [1:0]                ex_alu_sel;
  logic [DATA_WIDTH-1:0]     adder_data_out;
  logic [DATA_WIDTH-1:0]     shifter_data_out;
  logic                      shifter_output_vld;
  logic [DATA_WIDTH-1:0]     logic_data_out;
  logic [DATA_WIDTH-1:0]     cmp_data_out;
  // MEM side
  logic                      mem_vld;
  logic                      mem_ready;
  logic [PC_WIDTH-1:0]       mem_pc;
  logic [REG_ADDR_WIDTH-1:0] mem_rd;
  logic                      mem_rd_wen;
  logic [DATA_WIDTH-1:0]     mem_alu_result;
  logic                      mem_illegal_op;
  // forwarding and status
  logic                      fwd_vld;
  logic [REG_ADDR_WIDTH-1:0] fwd_rd;
  logic [DATA_WIDTH-1:0]     fwd_data;
  logic [CNT_WIDTH-1:0]      illegal_cnt;

  // Register view.
  modport slave (
    input  ex_vld, ex_kill, pipe_flush, ex_pc, ex_rd, ex_rd_wen, ex_alu_sel,
           adder_data_out, shifter_data_out, shifter_output_vld,
           logic_data_out, cmp_data_out, mem_ready,
    output ex_ready, mem_vld, mem_pc, mem_rd, mem_rd_wen, mem_alu_result,
           mem_illegal_op, fwd_vld, fwd_rd, fwd_data, illegal_cnt
  );

  // Surrounding pipeline view.
  modport master (
    output ex_vld, ex_kill, pipe_flush, ex_pc, ex_rd, ex_rd_wen, ex_alu_sel,
           adder_data_out, shifter_data_out, shifter_output_vld,
           logic_data_out, cmp_data_out, mem_ready,
    input  ex_ready, mem_vld, mem_pc, mem_rd, mem_rd_wen, mem_alu_result,
           mem_illegal_op, fwd_vld, fwd_rd, fwd_data, illegal_cnt
  );
endinterface

// File: rtl/iex_result_reg.sv
// EX-to-MEM pipeline register: selects the active ALU sub-unit result,
// screens illegal shifter ops, registers result plus destination info under
// a valid/ready handshake with kill/flush, drives the EX/MEM forwarding bus
// and keeps a saturating count of captured illegal ops.
module iex_result_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PC_WIDTH       = 32,
  parameter int CNT_WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  iex_result_reg_if.slave  bus
);

  localparam logic [1:0] SEL_ADD = 2'd0;
  localparam logic [1:0] SEL_SHF = 2'd1;
  localparam logic [1:0] SEL_LOG = 2'd2;
  localparam logic [1:0] SEL_CMP = 2'd3;

  logic                      vld_q;
  logic [PC_WIDTH-1:0]       pc_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic                      rd_wen_q;
  logic [DATA_WIDTH-1:0]     result_q;
  logic                      illegal_q;
  logic [CNT_WIDTH-1:0]      cnt_q;

  logic                      ready;
  logic                      fire;
  logic                      illegal;
  logic [DATA_WIDTH-1:0]     sel_result;
  logic [DATA_WIDTH-1:0]     cap_result;
  logic                      cap_wen;

  // Handshake: flush blocks capture; otherwise accept when empty or draining.
  always_comb begin
    ready = !bus.pipe_flush && (!vld_q || bus.mem_ready);
    fire  = bus.ex_vld && ready && !bus.ex_kill;
  end

  // Result select and legality screen; illegal ops write nothing and carry 0.
  always_comb begin
    sel_result = '0;
    unique case (bus.ex_alu_sel)
      SEL_ADD: sel_result = bus.adder_data_out;
      SEL_SHF: sel_result = bus.shifter_data_out;
      SEL_LOG: sel_result = bus.logic_data_out;
      SEL_CMP: sel_result = bus.cmp_data_out;
    endcase
    illegal    = (bus.ex_alu_sel == SEL_SHF) && !bus.shifter_output_vld;
    cap_result = illegal ? '0 : sel_result;
    cap_wen    = bus.ex_rd_wen && !illegal && (bus.ex_rd != '0);
  end

  // Valid bit: flush wins, then capture, then drain; a stall holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
    end else if (bus.pipe_flush) begin
      vld_q <= 1'b0;
    end else if (fire) begin
      vld_q <= 1'b1;
    end else if (bus.mem_ready) begin
      vld_q <= 1'b0;
    end
  end

  // Payload: loads only on capture, otherwise holds (stale once drained).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      rd_q      <= '0;
      rd_wen_q  <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else if (fire) begin
      pc_q      <= bus.ex_pc;
      rd_q      <= bus.ex_rd;
      rd_wen_q  <= cap_wen;
      result_q  <= cap_result;
      illegal_q <= illegal;
    end
  end

  // Illegal-op counter: counts captured illegal ops, sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (fire && illegal && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.ex_ready       = ready;
  assign bus.mem_vld        = vld_q;
  assign bus.mem_pc         = pc_q;
  assign bus.mem_rd         = rd_q;
  assign bus.mem_rd_wen     = rd_wen_q;
  assign bus.mem_alu_result = result_q;
  assign bus.mem_illegal_op = illegal_q;
  assign bus.fwd_vld        = vld_q && rd_wen_q;
  assign bus.fwd_rd         = rd_q;
  assign bus.fwd_data       = result_q;
  assign bus.illegal_cnt    = cnt_q;

endmodule
